sid_adsr_mux: RTL and testbench
===============================

Name: sid_adsr_mux

Overview:
- Time-multiplexed ADSR envelope generator for six voices: 2 SIDs × 3 voices.
- Voice order is SID1 v1,v2,v3, then SID2 v1,v2,v3.
- Sits between sid_control (supplies per-voice envelope registers) and the voice DCA pipeline.
- Each voice advances exactly one SID (phi2) cycle per pass of the pipeline cycle counter. 8-bit env is output one voice per clk.

Parameters:
- FIRST_CYCLE, 5: pipeline cycle in which voice 0's envelope register is presented; voice v is presented at FIRST_CYCLE+v.

Ports:
- clk  in  1  system clock, the single clock.
- res  in  1  reset, asynchronous, active-high.
- cycle  in  5  pipeline cycle counter (sid::cycle_t), 0 = idle, 1..18 once per SID cycle.
- ereg  in  17  sid::envelope_reg_t {gate, attack[3:0], decay[3:0], sustain[3:0], release[3:0]} for the voice of the current cycle.
- env  out  8  envelope level (sid::reg8_t) of the voice processed in the previous cycle.

Behaviour:
- Per-voice state, six entries, register array async-cleared by res:
  - env_cnt 8b
  - rate_cnt 15b
  - exp_cnt 5b
  - state 2b (ATTACK, DECAY_SUSTAIN, RELEASE)
  - gate_prev 1b
  - hold_zero 1b
- Reset values: env=0, env_cnt=0, rate_cnt=0, exp_cnt=0, state=RELEASE, gate_prev=0, hold_zero=1.
- Processing slot: when cycle == FIRST_CYCLE+v (v=0..5), voice v's state is read, updated per the rules below, and written back. env <= updated env_cnt on the same edge.
  - Latency is 1 clk: env for voice v is valid during cycle FIRST_CYCLE+v+1. With the default, SID1 v3 is valid at cycle 8 and SID2 v3 at cycle 11.
  - Outside slots env holds its value; cycles 0 and ≥FIRST_CYCLE+6 change no state.
- Gate edges, evaluated first in the slot:
  - 0→1: state=ATTACK, hold_zero=0.
  - 1→0: state=RELEASE.
  - gate_prev <= gate.
- Rate select: ATTACK uses attack, DECAY_SUSTAIN uses decay, RELEASE uses release.
  - Period table: 9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907, 11720, 19532, 31251.
- Rate counter: next = rate_cnt+1, modulo 2^15.
  - If next == period: rate_cnt=0, rate_tick=1.
  - Else: rate_cnt=next.
  - Reproduces the ADSR delay bug: a period lowered below the current count waits for the 15-bit wrap.
- On rate_tick:
  - ATTACK: exp_cnt=0; env_cnt+1 unless hold_zero. When the result is 0xFF, state=DECAY_SUSTAIN.
  - DECAY_SUSTAIN / RELEASE: exp_cnt+1. When it reaches the exponential period: exp_cnt=0, then decrement env_cnt unless:
    - DECAY_SUSTAIN with env_cnt == sustain*17, or
    - hold_zero.
  - Exponential period from current env_cnt: ≥0x5E:1, ≥0x37:2, ≥0x1B:4, ≥0x0F:8, ≥0x07:16, ≥0x01:30, 0x00:1.
  - env_cnt reaching 0 sets hold_zero=1; it is cleared only by a gate 0→1.
- No 8-bit wrap in either direction.
- res asserted mid-operation returns all voices and env to reset values immediately. Processing resumes at the first slot after deassertion.

Decomposition:
- Package sid: cycle_t, reg8_t, envelope_reg_t, envelope state enum, rate-period table as constant function.
- One combinational sub-module sid_adsr_step: computes the next per-voice state from current state + ereg. The top holds the state array and slot decode.

Test Plan:
1. Reset:
   - Stimulus: assert res mid-run.
   - Required: env=0 at once; every slot outputs 0 with gate=0 for 100 SID cycles.
2. Attack:
   - Stimulus: voice 0 gate=1, attack=0, decay=0, sustain=0xF.
   - Required: env increments every 9 SID cycles; reaches 0xFF after 2295 SID cycles; holds 0xFF (sustain 0xFF).
3. Decay to sustain:
   - Stimulus: after env=0xFF, sustain=0xA, decay=0.
   - Required: env falls and settles exactly at 0xAA, then holds.
4. Release / hold-zero:
   - Stimulus: gate 1→0, release=0.
   - Required: env reaches 0x00 with exponential spacing (step interval 9×30 below 0x07); stays 0 for 10000 SID cycles.
   - Required: gate 0→1 restarts attack from 0.
5. Voice isolation:
   - Stimulus: drive SID2 v3 (slot 5) only.
   - Required: its env appears at cycle FIRST_CYCLE+6; voices 0-4 remain 0.
6. Rate bug:
   - Stimulus: attack=0xF for 100 SID cycles, then attack=0.
   - Required: the next increment occurs only after rate_cnt wraps at 32768.

Source files
------------

// File: rtl/sid.sv
// Shared types and lookup tables for the multiplexed SID envelope generator.
// The rate table holds SID phi2 cycles per envelope step for each 4-bit rate setting.
package sid;

  typedef logic [4:0] cycle_t;
  typedef logic [7:0] reg8_t;

  typedef struct packed {
    logic       gate;
    logic [3:0] attack;
    logic [3:0] decay;
    logic [3:0] sustain;
    logic [3:0] rel;
  } envelope_reg_t;

  typedef enum logic [1:0] {
    ST_ATTACK        = 2'd0,
    ST_DECAY_SUSTAIN = 2'd1,
    ST_RELEASE       = 2'd2
  } env_state_e;

  typedef struct packed {
    reg8_t       env_cnt;
    logic [14:0] rate_cnt;
    logic [4:0]  exp_cnt;
    env_state_e  state;
    logic        gate_prev;
    logic        hold_zero;
  } voice_state_t;

  localparam int NUM_VOICES = 6;

  localparam voice_state_t VOICE_RESET = '{
    env_cnt:   8'h00,
    rate_cnt:  15'h0000,
    exp_cnt:   5'h00,
    state:     ST_RELEASE,
    gate_prev: 1'b0,
    hold_zero: 1'b1
  };

  function automatic logic [14:0] rate_period(input logic [3:0] sel);
    logic [14:0] p;
    case (sel)
      4'd0:    p = 15'd9;
      4'd1:    p = 15'd32;
      4'd2:    p = 15'd63;
      4'd3:    p = 15'd95;
      4'd4:    p = 15'd149;
      4'd5:    p = 15'd220;
      4'd6:    p = 15'd267;
      4'd7:    p = 15'd313;
      4'd8:    p = 15'd392;
      4'd9:    p = 15'd977;
      4'd10:   p = 15'd1954;
      4'd11:   p = 15'd3126;
      4'd12:   p = 15'd3907;
      4'd13:   p = 15'd11720;
      4'd14:   p = 15'd19532;
      default: p = 15'd31251;
    endcase
    return p;
  endfunction

  // Piecewise-linear approximation of the exponential decay curve.
  function automatic logic [4:0] exp_period(input reg8_t e);
    logic [4:0] p;
    if      (e >= 8'h5E) p = 5'd1;
    else if (e >= 8'h37) p = 5'd2;
    else if (e >= 8'h1B) p = 5'd4;
    else if (e >= 8'h0F) p = 5'd8;
    else if (e >= 8'h07) p = 5'd16;
    else if (e >= 8'h01) p = 5'd30;
    else                 p = 5'd1;
    return p;
  endfunction

endpackage

// File: rtl/sid_adsr_step.sv
// One SID cycle of ADSR envelope advance for a single voice, purely combinational.
// Shared by all six voices; the caller presents the state of the voice in its slot.
module sid_adsr_step
  import sid::*;
(
  input  voice_state_t  cur,
  input  envelope_reg_t ereg,
  output voice_state_t  nxt
);

  env_state_e  state_s;
  logic        hold_s;
  logic [3:0]  rate_sel;
  logic [14:0] period;
  logic [14:0] rate_inc;
  logic        rate_tick;
  reg8_t       env_s;
  logic [4:0]  exp_s;

  always_comb begin
    state_s = cur.state;
    hold_s  = cur.hold_zero;
    if (ereg.gate && !cur.gate_prev) begin
      state_s = ST_ATTACK;
      hold_s  = 1'b0;
    end else if (!ereg.gate && cur.gate_prev) begin
      state_s = ST_RELEASE;
    end

    case (state_s)
      ST_ATTACK:        rate_sel = ereg.attack;
      ST_DECAY_SUSTAIN: rate_sel = ereg.decay;
      default:          rate_sel = ereg.rel;
    endcase

    // Equality-only compare: lowering the period below the count waits for the 15-bit wrap.
    period    = rate_period(rate_sel);
    rate_inc  = cur.rate_cnt + 15'd1;
    rate_tick = (rate_inc == period);

    env_s = cur.env_cnt;
    exp_s = cur.exp_cnt;
    if (rate_tick) begin
      if (state_s == ST_ATTACK) begin
        exp_s = 5'd0;
        if (!hold_s && env_s != 8'hFF) env_s = env_s + 8'd1;
        if (env_s == 8'hFF) state_s = ST_DECAY_SUSTAIN;
      end else begin
        exp_s = exp_s + 5'd1;
        if (exp_s == exp_period(cur.env_cnt)) begin
          exp_s = 5'd0;
          if (!hold_s && env_s != 8'h00 &&
              !(state_s == ST_DECAY_SUSTAIN && env_s == {ereg.sustain, ereg.sustain})) begin
            env_s = env_s - 8'd1;
            if (env_s == 8'h00) hold_s = 1'b1;
          end
        end
      end
    end

    nxt.env_cnt   = env_s;
    nxt.rate_cnt  = rate_tick ? 15'd0 : rate_inc;
    nxt.exp_cnt   = exp_s;
    nxt.state     = state_s;
    nxt.gate_prev = ereg.gate;
    nxt.hold_zero = hold_s;
  end

endmodule

// File: rtl/sid_adsr_mux.sv
// Six-voice time-multiplexed ADSR: voice v is advanced in pipeline cycle FIRST_CYCLE+v,
// and its new level appears on env one clock later.
module sid_adsr_mux
  import sid::*;
#(
  parameter int FIRST_CYCLE = 5
) (
  input  logic          clk,
  input  logic          res,
  input  cycle_t        cycle,
  input  envelope_reg_t ereg,
  output reg8_t         env
);

  voice_state_t voice_q [NUM_VOICES];
  voice_state_t voice_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] slot_hit;
  logic [2:0]   slot_idx;
  logic         slot_valid;
  voice_state_t step_cur;
  voice_state_t step_nxt;
  reg8_t        env_q;
  reg8_t        env_d;

  always_comb begin
    slot_idx = 3'd0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (slot_hit[v]) slot_idx = 3'(v);
    end
    slot_valid = |slot_hit;
    step_cur   = voice_q[slot_idx];
  end

  sid_adsr_step u_step (
    .cur  (step_cur),
    .ereg (ereg),
    .nxt  (step_nxt)
  );

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    assign slot_hit[gi] = (int'(cycle) == FIRST_CYCLE + gi);

    always_comb begin
      voice_d[gi] = slot_hit[gi] ? step_nxt : voice_q[gi];
    end

    always_ff @(posedge clk or posedge res) begin
      if (res) voice_q[gi] <= VOICE_RESET;
      else     voice_q[gi] <= voice_d[gi];
    end
  end

  always_comb begin
    env_d = slot_valid ? step_nxt.env_cnt : env_q;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) env_q <= 8'h00;
    else     env_q <= env_d;
  end

  assign env = env_q;

endmodule

// File: tb/tb_sid_adsr_mux.sv
// Directed bench for sid_adsr_mux: a voice-0 envelope walk from a vector table, then
// hand-written sequences for asynchronous reset and slot isolation/latency.
module tb_sid_adsr_mux;
  import sid::*;

  localparam int FIRST = 5;

  logic          clk = 1'b0;
  logic          res;
  cycle_t        cycle;
  envelope_reg_t ereg;
  reg8_t         env;

  always #5 clk = ~clk;

  sid_adsr_mux #(.FIRST_CYCLE(FIRST)) dut (
    .clk   (clk),
    .res   (res),
    .cycle (cycle),
    .ereg  (ereg),
    .env   (env)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       gate;
    logic [3:0] a;
    logic [3:0] d;
    logic [3:0] s;
    logic [3:0] r;
    int         steps;
    logic [7:0] exp_env;
    string      name;
  } vec_t;

  vec_t vecs[$];

  envelope_reg_t voice_ereg [6];
  reg8_t         obs [19];

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void add(input logic g, input logic [3:0] a, input logic [3:0] d,
                              input logic [3:0] s, input logic [3:0] r, input int n,
                              input logic [7:0] e, input string nm);
    vec_t t;
    t.gate = g; t.a = a; t.d = d; t.s = s; t.r = r;
    t.steps = n; t.exp_env = e; t.name = nm;
    vecs.push_back(t);
  endfunction

  // Holding cycle at voice 0's slot advances voice 0 by one SID cycle per clock.
  task automatic run_v0(input int n);
    cycle = cycle_t'(FIRST);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    cycle = 5'd0;
  endtask

  // One full pipeline pass 0..18; junk ereg outside the slots must be ignored.
  task automatic sid_sweep();
    for (int c = 0; c < 19; c++) begin
      cycle = 5'(c);
      ereg  = (c >= FIRST && c < FIRST + 6) ? voice_ereg[c - FIRST] : 17'h1FFFF;
      @(posedge clk);
      #1;
      obs[c] = env;
    end
    cycle = 5'd0;
    ereg  = '0;
  endtask

  initial begin
    // Cumulative voice-0 walk: each row applies ereg, advances `steps` SID cycles, checks env.
    add(1, 0, 0, 4'hF, 0,     8, 8'h00, "attack_before_first_tick");
    add(1, 0, 0, 4'hF, 0,     1, 8'h01, "attack_first_tick");
    add(1, 0, 0, 4'hF, 0,  2285, 8'hFE, "attack_step_2294");
    add(1, 0, 0, 4'hF, 0,     1, 8'hFF, "attack_peak_2295");
    add(1, 0, 0, 4'hF, 0,   495, 8'hFF, "sustain_ff_hold");
    add(1, 0, 0, 4'hA, 0,     9, 8'hFE, "decay_first_step");
    add(1, 0, 0, 4'hA, 0,   755, 8'hAB, "decay_just_above_sustain");
    add(1, 0, 0, 4'hA, 0,     1, 8'hAA, "decay_reaches_sustain");
    add(1, 0, 0, 4'hA, 0,   900, 8'hAA, "sustain_aa_hold");
    add(0, 0, 0, 4'hA, 0,     9, 8'hA9, "release_first_step");
    add(0, 0, 0, 4'hA, 0,  4410, 8'h06, "release_reach_06");
    add(0, 0, 0, 4'hA, 0,   269, 8'h06, "release_06_before_270");
    add(0, 0, 0, 4'hA, 0,     1, 8'h05, "release_06_to_05_at_270");
    add(0, 0, 0, 4'hA, 0,  1349, 8'h01, "release_at_01");
    add(0, 0, 0, 4'hA, 0,     1, 8'h00, "release_reaches_zero");
    add(0, 0, 0, 4'hA, 0, 10008, 8'h00, "hold_zero_10000");
    add(1, 0, 0, 4'hA, 0,     8, 8'h00, "retrigger_before_tick");
    add(1, 0, 0, 4'hA, 0,     1, 8'h01, "retrigger_from_zero");
    add(1, 4'hF, 0, 4'hA, 0, 100, 8'h01, "ratebug_slow_attack");
    add(1, 0, 0, 4'hA, 0, 32676, 8'h01, "ratebug_waiting_wrap");
    add(1, 0, 0, 4'hA, 0,     1, 8'h02, "ratebug_tick_after_wrap");

    res   = 1'b1;
    cycle = 5'd0;
    ereg  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_env", int'(env), 0);
    res = 1'b0;

    foreach (vecs[i]) begin
      ereg.gate    = vecs[i].gate;
      ereg.attack  = vecs[i].a;
      ereg.decay   = vecs[i].d;
      ereg.sustain = vecs[i].s;
      ereg.rel     = vecs[i].r;
      run_v0(vecs[i].steps);
      check(vecs[i].name, int'(env), int'(vecs[i].exp_env));
    end

    // Asynchronous reset mid-run: env must clear before any further clock edge.
    #2 res = 1'b1;
    #1 check("async_reset_immediate", int'(env), 0);
    @(posedge clk);
    #1;
    res = 1'b0;
    for (int v = 0; v < 6; v++) voice_ereg[v] = '{gate: 1'b0, attack: 4'h0, decay: 4'h0,
                                                   sustain: 4'h0, rel: 4'h0};
    for (int k = 0; k < 100; k++) begin
      sid_sweep();
      for (int v = 0; v < 6; v++) check($sformatf("post_reset_k%0d_v%0d", k, v),
                                        int'(obs[FIRST + v]), 0);
    end

    // Voice isolation: only SID2 v3 is gated; it is the last slot.
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    voice_ereg[5] = '{gate: 1'b1, attack: 4'h0, decay: 4'h0, sustain: 4'hF, rel: 4'h0};
    repeat (8) sid_sweep();
    check("iso_v5_before_tick", int'(obs[FIRST + 5]), 0);
    sid_sweep();
    for (int v = 0; v < 5; v++) check($sformatf("iso_v%0d_zero", v), int'(obs[FIRST + v]), 0);
    check("iso_v5_cycle11", int'(obs[FIRST + 5]), 1);
    check("iso_v5_holds_to_cycle18", int'(obs[18]), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
